// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared CSR addresses, CSR op encodings, interrupt codes and FSM states
package trap_ctrl_pkg;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [1:0]  CSR_RW     = 2'b01;
    localparam logic [1:0]  CSR_RS     = 2'b10;
    localparam logic [1:0]  CSR_RC     = 2'b11;
    localparam logic [3:0]  IRQ_MSI    = 4'd3;
    localparam logic [3:0]  IRQ_MTI    = 4'd7;
    localparam logic [3:0]  IRQ_MEI    = 4'd11;
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, REDIR} state_t;
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: CSR-file link of the trap sequencer
// master (trap_ctrl): drives csraddr/funct/wdata/wen, reads mtvec/mepc/mie
// slave  (CSR file) : the opposite directions
interface trap_ctrl_if #(parameter int XLEN = 64);
    logic [11:0]     csraddr;
    logic [1:0]      funct;
    logic [XLEN-1:0] wdata;
    logic            wen;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mie;
    modport master (output csraddr, funct, wdata, wen, input mtvec, mepc, mie);
    modport slave  (input csraddr, funct, wdata, wen, output mtvec, mepc, mie);
endinterface

// File: rtl/trap_ctrl_irq_arb.sv
// trap_ctrl_irq_arb: combinational machine interrupt select, MEI > MSI > MTI
// in : irq_pending, mie, gie
// out: hit (an enabled interrupt is pending), code (its cause code)
module trap_ctrl_irq_arb
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] irq_pending,
    input  logic [XLEN-1:0] mie,
    input  logic            gie,
    output logic            hit,
    output logic [3:0]      code
);
    logic [XLEN-1:0] act;
    logic            unused_act;
    assign act        = gie ? (irq_pending & mie) : '0;
    assign unused_act = ^act;
    always_comb begin
        hit  = act[IRQ_MEI] | act[IRQ_MSI] | act[IRQ_MTI];
        code = act[IRQ_MEI] ? IRQ_MEI : act[IRQ_MSI] ? IRQ_MSI : act[IRQ_MTI] ? IRQ_MTI : 4'd0;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (mepc/mcause/mtval writes, then PC redirect)
// in : clk, rst (async, active-high), exc_*, mret_valid, int_pc, irq_pending, gie
// csr: trap_ctrl_if.master (csraddr/funct/wdata/wen out; mtvec/mepc/mie in)
// out: busy, trap_ack, redirect_valid, redirect_pc (all registered)
// TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==2'b01
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] int_pc,
    input  logic [XLEN-1:0] irq_pending,
    input  logic            gie,
    trap_ctrl_if.master     csr,
    output logic            busy,
    output logic            trap_ack,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    state_t          state, state_d;
    logic [XLEN-1:0] epc_q, cause_q, tval_q, target_q;
    logic [XLEN-1:0] epc_d, cause_d, tval_d, target_d, base;
    logic            hit, take_irq, take_trap, unused_mtvec;
    logic [3:0]      code;
    trap_ctrl_irq_arb #(.XLEN(XLEN)) u_arb (
        .irq_pending(irq_pending),
        .mie        (csr.mie),
        .gie        (gie),
        .hit        (hit),
        .code       (code)
    );
    assign base         = {csr.mtvec[XLEN-1:2], 2'b00};
    assign unused_mtvec = ^csr.mtvec[1:0];
    always_comb begin
        take_irq  = state == IDLE && !exc_valid && !mret_valid && hit;
        take_trap = (state == IDLE && exc_valid) || take_irq;
        epc_d     = epc_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        target_d  = target_q;
        if (state == IDLE && exc_valid) begin
            epc_d    = exc_pc;
            cause_d  = XLEN'(exc_cause);
            tval_d   = exc_tval;
            target_d = base;
        end else if (state == IDLE && mret_valid) begin
            target_d = csr.mepc;
        end else if (take_irq) begin
            epc_d    = int_pc;
            cause_d  = {1'b1, {(XLEN-5){1'b0}}, code};
            tval_d   = '0;
`ifdef TRAP_VECTORED_EN
            target_d = csr.mtvec[1:0] == 2'b01 ? base + {{(XLEN-6){1'b0}}, code, 2'b00} : base;
`else
            target_d = base;
`endif
        end
        state_d = state == IDLE    ? (take_trap ? W_EPC : mret_valid ? REDIR : IDLE) :
                  state == W_EPC   ? W_CAUSE :
                  state == W_CAUSE ? W_TVAL  :
                  state == W_TVAL  ? REDIR   : IDLE;
    end
    // Outputs are registered from the next state so each appears in the cycle its state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            epc_q          <= '0;
            cause_q        <= '0;
            tval_q         <= '0;
            target_q       <= '0;
            csr.csraddr    <= '0;
            csr.funct      <= '0;
            csr.wdata      <= '0;
            csr.wen        <= 1'b0;
            busy           <= 1'b0;
            trap_ack       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            tval_q         <= tval_d;
            target_q       <= target_d;
            csr.funct      <= CSR_RW;
            csr.wen        <= state_d inside {W_EPC, W_CAUSE, W_TVAL};
            csr.csraddr    <= state_d == W_EPC ? CSR_MEPC : state_d == W_CAUSE ? CSR_MCAUSE :
                              state_d == W_TVAL ? CSR_MTVAL : 12'h000;
            csr.wdata      <= state_d == W_EPC ? epc_d : state_d == W_CAUSE ? cause_d :
                              state_d == W_TVAL ? tval_d : '0;
            busy           <= state_d != IDLE;
            trap_ack       <= state == IDLE && state_d != IDLE;
            redirect_valid <= state_d == REDIR;
            redirect_pc    <= state_d == REDIR ? target_d : '0;
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a request-level model
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;
    localparam int XLEN = 64;
    typedef struct {
        logic        wen;
        logic [11:0] a;
        logic [63:0] d;
        logic        ack;
        logic        rv;
        logic [63:0] rpc;
        logic        busy;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_valid, mret_valid, gie;
    logic [3:0]  exc_cause;
    logic [63:0] exc_pc, exc_tval, int_pc, irq_pending;
    logic        busy, trap_ack, redirect_valid;
    logic [63:0] redirect_pc;
    int          checks = 0;
    int          errors = 0;
    trap_ctrl_if #(.XLEN(XLEN)) csr ();
    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_pc        (exc_pc),
        .exc_tval      (exc_tval),
        .mret_valid    (mret_valid),
        .int_pc        (int_pc),
        .irq_pending   (irq_pending),
        .gie           (gie),
        .csr           (csr.master),
        .busy          (busy),
        .trap_ack      (trap_ack),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic set_req(input logic ev, input logic [3:0] ec, input logic [63:0] epc, input logic [63:0] etv,
                           input logic mv, input logic [63:0] ipc, input logic [63:0] pend, input logic g,
                           input logic [63:0] tvec, input logic [63:0] mepc, input logic [63:0] ie);
        exc_valid   = ev;
        exc_cause   = ec;
        exc_pc      = epc;
        exc_tval    = etv;
        mret_valid  = mv;
        int_pc      = ipc;
        irq_pending = pend;
        gie         = g;
        csr.mtvec   = tvec;
        csr.mepc    = mepc;
        csr.mie     = ie;
    endtask
    task automatic set_idle();
        set_req(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    endtask
    // Requests presented while the block is busy must be ignored.
    task automatic set_junk();
        set_req(1'($urandom_range(0, 1)), 4'($urandom), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                rnd64(), rnd64(), 1'b1, rnd64(), rnd64(), rnd64());
    endtask
    task automatic chk_quiet(input string name);
        chk({name, "/wen"}, 64'(csr.wen), 64'd0);
        chk({name, "/csraddr"}, 64'(csr.csraddr), 64'd0);
        chk({name, "/wdata"}, csr.wdata, 64'd0);
        chk({name, "/busy"}, 64'(busy), 64'd0);
        chk({name, "/trap_ack"}, 64'(trap_ack), 64'd0);
        chk({name, "/redirect_valid"}, 64'(redirect_valid), 64'd0);
        chk({name, "/redirect_pc"}, redirect_pc, 64'd0);
    endtask
    // Model: the currently driven inputs form the request of cycle T; the expected
    // per-cycle output trace from T+1 until the block is idle again is derived here.
    task automatic run_req(input string name);
        exp_t        q[$];
        exp_t        e;
        logic [63:0] act, base, cause, tgt;
        int          code;
        act  = gie ? (irq_pending & csr.mie) : 64'd0;
        code = act[11] ? 11 : act[3] ? 3 : act[7] ? 7 : -1;
        base = {csr.mtvec[63:2], 2'b00};
        if (exc_valid) begin
            cause = {60'd0, exc_cause};
            q.push_back(exp_t'{1'b1, 12'h341, exc_pc, 1'b1, 1'b0, 64'd0, 1'b1});
            q.push_back(exp_t'{1'b1, 12'h342, cause, 1'b0, 1'b0, 64'd0, 1'b1});
            q.push_back(exp_t'{1'b1, 12'h343, exc_tval, 1'b0, 1'b0, 64'd0, 1'b1});
            q.push_back(exp_t'{1'b0, 12'h000, 64'd0, 1'b0, 1'b1, base, 1'b1});
        end else if (mret_valid) begin
            q.push_back(exp_t'{1'b0, 12'h000, 64'd0, 1'b1, 1'b1, csr.mepc, 1'b1});
        end else if (code >= 0) begin
            cause = {1'b1, 59'd0, 4'(code)};
            tgt   = base;
`ifdef TRAP_VECTORED_EN
            if (csr.mtvec[1:0] == 2'b01) tgt = base + 64'(4 * code);
`endif
            q.push_back(exp_t'{1'b1, 12'h341, int_pc, 1'b1, 1'b0, 64'd0, 1'b1});
            q.push_back(exp_t'{1'b1, 12'h342, cause, 1'b0, 1'b0, 64'd0, 1'b1});
            q.push_back(exp_t'{1'b1, 12'h343, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1});
            q.push_back(exp_t'{1'b0, 12'h000, 64'd0, 1'b0, 1'b1, tgt, 1'b1});
        end
        q.push_back(exp_t'{1'b0, 12'h000, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0});
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            e = q[i];
            chk({name, "/wen"}, 64'(csr.wen), 64'(e.wen));
            chk({name, "/csraddr"}, 64'(csr.csraddr), 64'(e.a));
            chk({name, "/wdata"}, csr.wdata, e.d);
            chk({name, "/trap_ack"}, 64'(trap_ack), 64'(e.ack));
            chk({name, "/redirect_valid"}, 64'(redirect_valid), 64'(e.rv));
            chk({name, "/busy"}, 64'(busy), 64'(e.busy));
            if (e.rv) chk({name, "/redirect_pc"}, redirect_pc, e.rpc);
            if (e.wen) chk({name, "/funct"}, 64'(csr.funct), 64'(CSR_RW));
            if (i < q.size() - 1) set_junk();
        end
        set_idle();
    endtask
    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset/funct", 64'(csr.funct), 64'd0);
        rst = 1'b0;
        set_req(1'b1, 4'd2, 64'h1000, 64'hDEAD, 1'b0, 64'd0, 64'd0, 1'b0, 64'h8000_0100, 64'd0, 64'd0);
        run_req("exc");
        set_req(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 64'h2004, 64'h880, 1'b1, 64'h8000_0100, 64'd0, 64'h880);
        run_req("irq_mei");
        set_req(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 64'h8000_0100, 64'h3000, 64'd0);
        run_req("mret");
        set_req(1'b1, 4'd5, 64'h5000, 64'h77, 1'b1, 64'h6000, 64'h80, 1'b1, 64'h8000_0100, 64'h3000, 64'h80);
        run_req("simul");
        set_req(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 64'h6000, 64'h80, 1'b1, 64'h8000_0100, 64'h3000, 64'h80);
        run_req("mti_retake");
        set_req(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 64'h7000, 64'h80, 1'b1, 64'h4001, 64'd0, 64'h80);
        run_req("vec_mti");
        set_req(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 64'h7000, 64'h8, 1'b0, 64'h4001, 64'd0, 64'h8);
        run_req("gie_off");
        set_req(1'b1, 4'd4, 64'h9000, 64'hBEEF, 1'b0, 64'd0, 64'd0, 1'b0, 64'h100, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        set_idle();
        chk("rst_mid/epc_addr", 64'(csr.csraddr), 64'h341);
        @(posedge clk);
        #1;
        chk("rst_mid/cause_addr", 64'(csr.csraddr), 64'h342);
        rst = 1'b1;
        #1;
        chk_quiet("rst_mid/async");
        @(posedge clk);
        #1;
        chk_quiet("rst_mid/held");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_quiet("rst_mid/after");
        set_req(1'b1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 1'b0, 64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
        run_req("post_rst");
        for (int n = 0; n < 40; n++) begin
            set_req($urandom_range(0, 3) == 0, 4'($urandom), rnd64(), rnd64(), $urandom_range(0, 3) == 0,
                    rnd64(), {52'($urandom), 12'($urandom) & 12'h888}, 1'($urandom_range(0, 3) != 0),
                    rnd64(), rnd64(), rnd64());
            run_req("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer. It sits between the pipeline's exception/interrupt sources and the CSR file.
- It arbitrates exceptions, MRET and enabled interrupts.
- It sequences the mepc/mcause/mtval writes through the CSR file's single write port.
- It then issues a one-cycle PC redirect to fetch, built from mtvec (trap entry) or mepc (MRET).

Parameters:
- XLEN, 64, datapath and CSR width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- exc_valid  in  1  synchronous exception request
- exc_cause  in  4  exception code
- exc_pc  in  XLEN  PC of faulting instruction
- exc_tval  in  XLEN  trap value
- mret_valid  in  1  MRET retiring
- int_pc  in  XLEN  PC of next unretired instruction (mepc for interrupts)
- irq_pending  in  XLEN  mip image (bit3 MSI, bit7 MTI, bit11 MEI)
- gie  in  1  global machine interrupt enable
- mtvec  in  XLEN  from CSR file
- mepc  in  XLEN  from CSR file
- mie  in  XLEN  from CSR file
- csraddr  out  12  CSR write address
- funct  out  2  CSR op; always CSR_RW
- wdata  out  XLEN  CSR write data
- wen  out  1  CSR write enable
- busy  out  1  stall request to pipeline
- trap_ack  out  1  one-cycle pulse when a request is accepted
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, rst high): FSM=IDLE; all outputs 0; internal capture registers 0.
- Reset mid-sequence aborts immediately. CSR writes already issued stay; no further writes are made.
- All outputs are registered.
- States:
  - IDLE
  - W_EPC
  - W_CAUSE
  - W_TVAL
  - REDIR
- Accept in IDLE, in cycle T, by priority:
  1. exc_valid
  2. mret_valid
  3. interrupt
- Interrupt condition: gie & |(irq_pending & mie & mask{11,3,7}).
- Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Lower-priority simultaneous events are dropped by this block.
  - Interrupts are level and are retaken later.
  - The pipeline re-presents a dropped MRET or exception after busy deasserts.
- On accept, capture:
  - epc = exc_pc for an exception, int_pc for an interrupt.
  - cause = {1'b0, zero-ext exc_cause} for an exception; {1'b1, zero-ext code} for an interrupt (MSB = bit XLEN-1).
  - tval = exc_tval for an exception, 0 for an interrupt.
  - target = redirect PC computed from mtvec sampled at T.
- Trap entry sequence:
  - T+1: W_EPC. wen=1, csraddr=0x341, wdata=epc, trap_ack=1, busy=1.
  - T+2: W_CAUSE. wen=1, csraddr=0x342, wdata=cause.
  - T+3: W_TVAL. wen=1, csraddr=0x343, wdata=tval.
  - T+4: REDIR. redirect_valid=1, redirect_pc=target, busy=1, wen=0.
  - T+5: back to IDLE; busy=0. A new request is acceptable in cycle T+5.
- MRET:
  - T+1: REDIR. trap_ack=1, redirect_valid=1, redirect_pc=mepc sampled at T, busy=1.
  - T+2: IDLE.
- Requests present while not in IDLE are ignored; no queueing.
- funct is always the shared CSR_RW encoding. wdata and csraddr are 0 when wen=0.
- Direct target: {mtvec[XLEN-1:2], 2'b00}.
- Address arithmetic is modulo 2^XLEN; wrap-around is permitted, not flagged.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when mtvec[1:0]==2'b01 and the trap is an interrupt, target = {mtvec[XLEN-1:2], 2'b00} + 4*code. Exceptions always use the direct base.
- Undefined: mtvec[1:0] is ignored; every trap uses the direct base.

Decomposition:
- Shared package/header:
  - CSR addresses: MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.
  - CSR_RW/RS/RC funct encodings.
  - Interrupt codes: MSI=3, MTI=7, MEI=11.
  - FSM state encoding.
- Sub-module irq_arb: combinational priority select of irq_pending & mie & gie. Outputs hit and a 4-bit code.

Test Plan:
- Exception, from reset with mtvec=0x8000_0100: exc_valid, exc_cause=2, exc_pc=0x1000, exc_tval=0xDEAD -> T+1 write 0x341←0x1000; T+2 write 0x342←2; T+3 write 0x343←0xDEAD; T+4 redirect to 0x8000_0100.
- Interrupt: gie=1, mie=irq_pending=0x880, int_pc=0x2004 -> MEI wins; mcause=0x8000_0000_0000_000B; mtval←0; mepc←0x2004.
- MRET with mepc=0x3000 -> T+1 redirect_valid=1 with redirect_pc=0x3000; no wen.
- Simultaneous exc_valid + mret_valid + enabled MTI -> exception sequence only. After busy drops, the still-pending MTI is taken with cause 0x8000_0000_0000_0007.
- TRAP_VECTORED_EN defined with mtvec=0x4001 and MTI -> redirect to 0x401C. Same setup with macro undefined -> redirect to 0x4000.
- Assert rst at T+2 of an exception sequence -> outputs 0 immediately; no 0x343 write; the next request is accepted normally.
